ras_ckpt: RTL

// - Parametrised return-address stack for the frontend branch predictor.
// - Generalises fixed-depth RAS configs: DEPTH/XLEN selectable, including 0-entry bypass.
// - Adds wrap-on-overflow, same-cycle push+pop, flush and optional mispredict checkpoint/restore.
// - Sits beside BTB/BHT in the frontend; the fetch stage pushes on calls and pops on returns.

---
 rtl/ras_ckpt_if.sv | 28 ++
 rtl/ras_ckpt.sv | 114 +++++++++++
 2 files changed

// File: rtl/ras_ckpt_if.sv
// Frontend-to-RAS bus: fetch stage (master) drives call/return requests, the stack (slave) reports its top.
interface ras_ckpt_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  // A 0-entry stack still needs a 1-bit count port
  localparam int CW = (DEPTH > 0) ? $clog2(DEPTH + 1) : 1;

  logic            flush_i;
  logic            push_i;
  logic            pop_i;
  logic [XLEN-1:0] data_i;
  logic            ckpt_i;
  logic            restore_i;
  logic [XLEN-1:0] data_o;
  logic            valid_o;
  logic [CW-1:0]   count_o;

  modport master (
    output flush_i, push_i, pop_i, data_i, ckpt_i, restore_i,
    input  data_o, valid_o, count_o
  );

  modport slave (
    input  flush_i, push_i, pop_i, data_i, ckpt_i, restore_i,
    output data_o, valid_o, count_o
  );
endinterface

// File: rtl/ras_ckpt.sv
// Circular return-address stack with wrap-on-overflow, flush and same-cycle push+pop.
// Optional mispredict checkpoint/restore is enabled by defining RAS_CKPT_EN.
module ras_ckpt #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  ras_ckpt_if.slave  bus
);
  localparam int CW = (DEPTH > 0) ? $clog2(DEPTH + 1) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH == 0) begin : g_bypass
    logic unused_s;
    assign unused_s    = ^{clk_i, rst_ni, bus.flush_i, bus.push_i, bus.pop_i,
                           bus.data_i, bus.ckpt_i, bus.restore_i};
    assign bus.data_o  = '0;
    assign bus.valid_o = 1'b0;
    assign bus.count_o = '0;
  end else begin : g_stack
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [XLEN-1:0] mem_d [DEPTH];
    logic [PW-1:0]   tos_q, tos_d, tos_inc_s, tos_dec_s;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Explicit wrap so non-power-of-two depths stay in range
    assign tos_inc_s = (tos_q == LAST_IDX) ? PW'(0) : tos_q + PW'(1);
    assign tos_dec_s = (tos_q == PW'(0))   ? LAST_IDX : tos_q - PW'(1);

`ifdef RAS_CKPT_EN
    logic [PW-1:0]   ck_tos_q, ck_tos_d;
    logic [CW-1:0]   ck_cnt_q, ck_cnt_d;
    logic [XLEN-1:0] ck_top_q, ck_top_d;

    // Snapshot only when neither flush nor restore claims the cycle
    always_comb begin
      ck_tos_d = ck_tos_q;
      ck_cnt_d = ck_cnt_q;
      ck_top_d = ck_top_q;
      if (bus.ckpt_i && !bus.flush_i && !bus.restore_i) begin
        ck_tos_d = tos_q;
        ck_cnt_d = cnt_q;
        ck_top_d = mem_q[tos_q];
      end else begin
        ck_tos_d = ck_tos_q;
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        ck_tos_q <= '0;
        ck_cnt_q <= '0;
        ck_top_q <= '0;
      end else begin
        ck_tos_q <= ck_tos_d;
        ck_cnt_q <= ck_cnt_d;
        ck_top_q <= ck_top_d;
      end
    end
`else
    logic unused_s;
    assign unused_s = ^{bus.ckpt_i, bus.restore_i};
`endif

    // Next-state: flush > restore > push/pop
    always_comb begin
      tos_d = tos_q;
      cnt_d = cnt_q;
      mem_d = mem_q;
      if (bus.flush_i) begin
        cnt_d = '0;
`ifdef RAS_CKPT_EN
      end else if (bus.restore_i) begin
        tos_d           = ck_tos_q;
        cnt_d           = ck_cnt_q;
        mem_d[ck_tos_q] = ck_top_q;
`endif
      end else if (bus.push_i && bus.pop_i) begin
        mem_d[tos_q] = bus.data_i;
      end else if (bus.push_i) begin
        tos_d            = tos_inc_s;
        mem_d[tos_inc_s] = bus.data_i;
        cnt_d            = (cnt_q == FULL_CNT) ? cnt_q : cnt_q + CW'(1);
      end else if (bus.pop_i && (cnt_q != '0)) begin
        tos_d = tos_dec_s;
        cnt_d = cnt_q - CW'(1);
      end else begin
        tos_d = tos_q;
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        tos_q <= '0;
        cnt_q <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[i] <= '0;
        end
      end else begin
        tos_q <= tos_d;
        cnt_q <= cnt_d;
        mem_q <= mem_d;
      end
    end

    assign bus.data_o  = mem_q[tos_q];
    assign bus.valid_o = (cnt_q != '0);
    assign bus.count_o = cnt_q;
  end
endmodule
